// File: rtl/multichannel_pattern_generator.sv
// -----------------------------------------------------------------------------
// multichannel_pattern_generator
//
// Captures one timestep of spikes per beat from N_CH channels into a
// T_WINDOW-bit temporal pattern per channel. Each closed window goes out
// through a single registered output slot. One capture window may wait
// behind the output slot in HOLD.
//
// Optional feature macro: MPG_POPCOUNT_EN
//   defined   -> popcnt_out port and per-channel spike counters are present
//   undefined -> no popcnt_out port and no counter logic
//
// Ports
//   clk            in   clock
//   rst            in   synchronous active-high reset
//   spike_valid    in   spike_in carries one timestep
//   spike_in       in   [N_CH]   channel c spike for this timestep
//   spike_ready    out  the block accepts a timestep (COLLECT, out of reset)
//   flush          in   close the current window early
//   pattern_valid  out  output window available
//   pattern_ready  in   consumer accepts the output window
//   pattern_out    out  [N_CH*T_WINDOW] bit c*T_WINDOW+t = channel c, step t
//   mask_out       out  [N_CH]   OR of each channel's pattern
//   win_len_out    out  [CNT_W]  timesteps captured in the window
//   popcnt_out     out  [N_CH*CNT_W] per-channel spike count (optional)
//   dbg_state      out  FSM state (0 = COLLECT, 1 = HOLD)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. A valid that is high stays high, with its data stable, until
// that transfer happens.
// -----------------------------------------------------------------------------
module multichannel_pattern_generator #(
    parameter int N_CH     = 4,
    parameter int T_WINDOW = 16,
    parameter int CNT_W    = $clog2(T_WINDOW + 1)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     spike_valid,
    input  logic [N_CH-1:0]          spike_in,
    output logic                     spike_ready,
    input  logic                     flush,
    output logic                     pattern_valid,
    input  logic                     pattern_ready,
    output logic [N_CH*T_WINDOW-1:0] pattern_out,
    output logic [N_CH-1:0]          mask_out,
    output logic [CNT_W-1:0]         win_len_out,
`ifdef MPG_POPCOUNT_EN
    output logic [N_CH*CNT_W-1:0]    popcnt_out,
`endif
    output logic [0:0]               dbg_state
);

    localparam logic [0:0] ST_COLLECT = 1'b0;
    localparam logic [0:0] ST_HOLD    = 1'b1;
    localparam logic [CNT_W-1:0] TS_LAST = CNT_W'(T_WINDOW - 1);

    logic [0:0]               r_state;
    logic                     r_run;       // low for the cycle after reset
    logic [CNT_W-1:0]         r_ts;
    logic [N_CH*T_WINDOW-1:0] r_cap;
    logic [CNT_W-1:0]         r_hold_len;  // length of the window parked in HOLD
    logic                     r_pv;
    logic [N_CH*T_WINDOW-1:0] r_pat;
    logic [N_CH-1:0]          r_mask;
    logic [CNT_W-1:0]         r_len;

    logic                     w_beat;
    logic                     w_close;
    logic                     w_drain;
    logic                     w_load;
    logic                     w_hold_enter;
    logic [N_CH*T_WINDOW-1:0] w_cap_next;
    logic [N_CH-1:0]          w_mask_next;
    logic [CNT_W-1:0]         w_len_next;

`ifdef MPG_POPCOUNT_EN
    logic [N_CH*CNT_W-1:0]    r_pop;
    logic [N_CH*CNT_W-1:0]    r_pop_out;
    logic [N_CH*CNT_W-1:0]    w_pop_next;
`endif

    assign spike_ready = (r_state == ST_COLLECT) && r_run;
    assign w_beat      = spike_valid && spike_ready;
    assign w_drain     = r_pv && pattern_ready;

    // A flush closes only a non-empty window (or one gaining a beat now).
    assign w_close = (r_state == ST_COLLECT) && r_run &&
                     ((w_beat && (r_ts == TS_LAST)) ||
                      (flush && ((r_ts != '0) || w_beat)));

    // Output slot takes new data when it is free or being emptied this edge,
    // or when HOLD sees the consumer take the current window.
    assign w_load       = (w_close && (!r_pv || w_drain)) ||
                          ((r_state == ST_HOLD) && pattern_ready);
    assign w_hold_enter = w_close && r_pv && !w_drain;

    // In HOLD no beat is accepted, so w_cap_next equals r_cap there.
    always_comb begin
        w_cap_next = r_cap;
        if (w_beat) begin
            for (int c = 0; c < N_CH; c++) begin
                w_cap_next[c*T_WINDOW + int'(r_ts)] = spike_in[c];
            end
        end
        for (int c = 0; c < N_CH; c++) begin
            w_mask_next[c] = |w_cap_next[c*T_WINDOW +: T_WINDOW];
        end
        w_len_next = (r_state == ST_HOLD) ? r_hold_len
                                          : (r_ts + CNT_W'(w_beat));
    end

`ifdef MPG_POPCOUNT_EN
    always_comb begin
        w_pop_next = r_pop;
        for (int c = 0; c < N_CH; c++) begin
            w_pop_next[c*CNT_W +: CNT_W] = r_pop[c*CNT_W +: CNT_W] +
                                           CNT_W'(w_beat && spike_in[c]);
        end
    end
    assign popcnt_out = r_pop_out;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_COLLECT;
            r_run      <= 1'b0;
            r_ts       <= '0;
            r_cap      <= '0;
            r_hold_len <= '0;
            r_pv       <= 1'b0;
            r_pat      <= '0;
            r_mask     <= '0;
            r_len      <= '0;
`ifdef MPG_POPCOUNT_EN
            r_pop      <= '0;
            r_pop_out  <= '0;
`endif
        end else begin
            r_run <= 1'b1;

            if (w_load) begin
                r_pv   <= 1'b1;
                r_pat  <= w_cap_next;
                r_mask <= w_mask_next;
                r_len  <= w_len_next;
`ifdef MPG_POPCOUNT_EN
                r_pop_out <= w_pop_next;
`endif
            end else if (w_drain) begin
                r_pv <= 1'b0;
            end

            if (w_load) begin
                // New window starts empty.
                r_cap   <= '0;
                r_ts    <= '0;
                r_state <= ST_COLLECT;
`ifdef MPG_POPCOUNT_EN
                r_pop   <= '0;
`endif
            end else if (w_hold_enter) begin
                r_cap      <= w_cap_next;
                r_hold_len <= w_len_next;
                r_state    <= ST_HOLD;
`ifdef MPG_POPCOUNT_EN
                r_pop      <= w_pop_next;
`endif
            end else if (w_beat) begin
                r_cap <= w_cap_next;
                r_ts  <= r_ts + 1'b1;
`ifdef MPG_POPCOUNT_EN
                r_pop <= w_pop_next;
`endif
            end
        end
    end

    assign pattern_valid = r_pv;
    assign pattern_out   = r_pat;
    assign mask_out      = r_mask;
    assign win_len_out   = r_len;
    assign dbg_state     = r_state;

endmodule

// File: tb/tb_multichannel_pattern_generator.sv
// -----------------------------------------------------------------------------
// tb_multichannel_pattern_generator
//
// Directed bench for multichannel_pattern_generator (N_CH=4, T_WINDOW=8).
// A window-level model keeps the accepted timesteps of the open window and a
// queue of closed windows awaiting the consumer; the front of that queue is
// what the outputs must show. Literal checks pin the hand-computed windows.
// -----------------------------------------------------------------------------
module tb_multichannel_pattern_generator;
    localparam int N_CH     = 4;
    localparam int T_WINDOW = 8;
    localparam int CNT_W    = $clog2(T_WINDOW + 1);
    localparam int PAT_W    = N_CH * T_WINDOW;
    localparam int POP_W    = N_CH * CNT_W;
    localparam int EXP_W    = PAT_W + N_CH + CNT_W + POP_W;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst = 1'b1;
    logic                 spike_valid = 1'b0;
    logic [N_CH-1:0]      spike_in = '0;
    logic                 flush = 1'b0;
    logic                 pattern_ready = 1'b0;
    logic                 spike_ready;
    logic                 pattern_valid;
    logic [PAT_W-1:0]     pattern_out;
    logic [N_CH-1:0]      mask_out;
    logic [CNT_W-1:0]     win_len_out;
    logic [POP_W-1:0]     popcnt_out;
    logic [0:0]           dbg_state;

`ifndef MPG_POPCOUNT_EN
    assign popcnt_out = '0;
`endif

    multichannel_pattern_generator #(
        .N_CH(N_CH), .T_WINDOW(T_WINDOW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .spike_valid(spike_valid),
        .spike_in(spike_in),
        .spike_ready(spike_ready),
        .flush(flush),
        .pattern_valid(pattern_valid),
        .pattern_ready(pattern_ready),
        .pattern_out(pattern_out),
        .mask_out(mask_out),
        .win_len_out(win_len_out),
`ifdef MPG_POPCOUNT_EN
        .popcnt_out(popcnt_out),
`endif
        .dbg_state(dbg_state)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- window-level model ----------------
    logic [EXP_W-1:0] exp_q[$];
    logic [N_CH-1:0]  m_steps[$];   // timesteps accepted in the open window
    bit               m_run   = 0;
    bit               started = 0;

    function automatic logic [EXP_W-1:0] pack_window();
        logic [PAT_W-1:0] pat;
        logic [N_CH-1:0]  msk;
        logic [POP_W-1:0] pop;
        int               cnt;
        pat = '0;
        pop = '0;
        msk = '0;
        for (int c = 0; c < N_CH; c++) begin
            cnt = 0;
            for (int t = 0; t < m_steps.size(); t++) begin
                pat[c*T_WINDOW + t] = m_steps[t][c];
                cnt += int'(m_steps[t][c]);
            end
            msk[c] = (cnt != 0);
            pop[c*CNT_W +: CNT_W] = CNT_W'(cnt);
        end
        return {pat, msk, CNT_W'(m_steps.size()), pop};
    endfunction

    always @(posedge clk) begin
        bit rdy, beat, close;
        if (rst) begin
            exp_q.delete();
            m_steps.delete();
            m_run   = 0;
            started = 1;
        end else if (started) begin
            // At most one window waits behind the output slot.
            rdy  = m_run && (exp_q.size() < 2);
            beat = spike_valid && rdy;
            if (beat) m_steps.push_back(spike_in);
            close = rdy && ((beat && m_steps.size() == T_WINDOW) ||
                            (flush && m_steps.size() > 0));
            if (exp_q.size() > 0 && pattern_ready) void'(exp_q.pop_front());
            if (close) begin
                exp_q.push_back(pack_window());
                m_steps.delete();
            end
            m_run = 1;
        end
    end

    // ---------------- scoreboard compare ----------------
    always @(negedge clk) begin
        logic [EXP_W-1:0] f;
        if (started) begin
            chk("spike_ready", 64'(spike_ready), 64'(m_run && exp_q.size() < 2));
            chk("pattern_valid", 64'(pattern_valid), 64'(exp_q.size() > 0));
            if (exp_q.size() > 0) begin
                f = exp_q[0];
                chk("pattern_out", 64'(pattern_out), 64'(f[EXP_W-1 -: PAT_W]));
                chk("mask_out", 64'(mask_out), 64'(f[CNT_W+POP_W +: N_CH]));
                chk("win_len_out", 64'(win_len_out), 64'(f[POP_W +: CNT_W]));
`ifdef MPG_POPCOUNT_EN
                chk("popcnt_out", 64'(popcnt_out), 64'(f[POP_W-1:0]));
`endif
            end
        end
    end

    // ---------------- driver ----------------
    task automatic drive(input logic v, input logic [N_CH-1:0] s,
                         input logic f, input logic r);
        spike_valid   = v;
        spike_in      = s;
        flush         = f;
        pattern_ready = r;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input logic r);
        drive(1'b0, '0, 1'b0, r);
    endtask

    // ---------------- directed tests ----------------
    initial begin
        // Reset state
        idle(1'b0);
        idle(1'b0);
        rst = 1'b0;
        chk("rst_spike_ready", 64'(spike_ready), 64'd0);
        chk("rst_valid", 64'(pattern_valid), 64'd0);
        chk("rst_pattern", 64'(pattern_out), 64'd0);
        chk("rst_mask", 64'(mask_out), 64'd0);
        chk("rst_len", 64'(win_len_out), 64'd0);
        chk("rst_pop", 64'(popcnt_out), 64'd0);
        idle(1'b1);
        chk("rst_ready_next", 64'(spike_ready), 64'd1);

        // 1: eight beats of ch0
        for (int i = 0; i < 8; i++) drive(1'b1, 4'b0001, 1'b0, 1'b1);
        chk("t1_valid", 64'(pattern_valid), 64'd1);
        chk("t1_pattern", 64'(pattern_out), 64'h0000_00FF);
        chk("t1_mask", 64'(mask_out), 64'h1);
        chk("t1_len", 64'(win_len_out), 64'd8);
`ifdef MPG_POPCOUNT_EN
        chk("t1_pop", 64'(popcnt_out), 64'h0008);
`endif
        idle(1'b1);
        chk("t1_valid_drop", 64'(pattern_valid), 64'd0);

        // 2: ch1 spikes at t=0 and t=5
        for (int i = 0; i < 8; i++)
            drive(1'b1, (i == 0 || i == 5) ? 4'h2 : 4'h0, 1'b0, 1'b1);
        chk("t2_pattern", 64'(pattern_out), 64'h0000_2100);
        chk("t2_mask", 64'(mask_out), 64'h2);
        idle(1'b1);

        // 3: three beats then a lone flush; an empty flush is ignored
        for (int i = 0; i < 3; i++) drive(1'b1, 4'hF, 1'b0, 1'b1);
        drive(1'b0, 4'h0, 1'b1, 1'b1);
        chk("t3_pattern", 64'(pattern_out), 64'h0707_0707);
        chk("t3_len", 64'(win_len_out), 64'd3);
        chk("t3_mask", 64'(mask_out), 64'hF);
        drive(1'b0, 4'h0, 1'b1, 1'b1);
        chk("t3_empty_flush", 64'(pattern_valid), 64'd0);
        idle(1'b1);

        // 4: consumer stalled, two windows streamed
        for (int i = 0; i < 16; i++) drive(1'b1, 4'(i), 1'b0, 1'b0);
        chk("t4_hold_ready", 64'(spike_ready), 64'd0);
        chk("t4_first_win", 64'(pattern_out), 64'h00F0_CCAA);
        drive(1'b1, 4'hF, 1'b1, 1'b0);   // beat and flush refused in HOLD
        chk("t4_first_stable", 64'(pattern_out), 64'h00F0_CCAA);
        chk("t4_first_mask", 64'(mask_out), 64'h7);
        idle(1'b1);
        chk("t4_valid_cont", 64'(pattern_valid), 64'd1);
        chk("t4_second_win", 64'(pattern_out), 64'hFFF0_CCAA);
        chk("t4_second_mask", 64'(mask_out), 64'hF);
        chk("t4_ready_back", 64'(spike_ready), 64'd1);
        idle(1'b1);
        chk("t4_drained", 64'(pattern_valid), 64'd0);

        // 5: reset with an undrained output and a partial window
        for (int i = 0; i < 8; i++) drive(1'b1, 4'h1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) drive(1'b1, 4'h3, 1'b0, 1'b0);
        rst = 1'b1;
        idle(1'b0);
        rst = 1'b0;
        chk("t5_valid", 64'(pattern_valid), 64'd0);
        chk("t5_pattern", 64'(pattern_out), 64'd0);
        chk("t5_mask", 64'(mask_out), 64'd0);
        chk("t5_len", 64'(win_len_out), 64'd0);
        idle(1'b1);
        for (int i = 0; i < 8; i++) drive(1'b1, 4'h4, 1'b0, 1'b1);
        chk("t5_clean_win", 64'(pattern_out), 64'h00FF_0000);
        chk("t5_clean_len", 64'(win_len_out), 64'd8);
        idle(1'b1);

        // 6: flush coincident with beat 4
        for (int i = 0; i < 3; i++) drive(1'b1, 4'h0, 1'b0, 1'b1);
        drive(1'b1, 4'h8, 1'b1, 1'b1);
        chk("t6_pattern", 64'(pattern_out), 64'h0800_0000);
        chk("t6_len", 64'(win_len_out), 64'd4);
        chk("t6_mask", 64'(mask_out), 64'h8);
        idle(1'b1);

        // Back-to-back windows with a keeping-up consumer
        for (int i = 0; i < 16; i++) drive(1'b1, 4'(i * 5), 1'b0, 1'b1);
        // Occasional consumer stalls mixed with beats and flushes
        for (int i = 0; i < 24; i++)
            drive(1'b1, 4'(i * 3 + 1), (i % 7) == 6, (i % 3) != 0);
        for (int i = 0; i < 4; i++) idle(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
